layer_mem_arb: RTL and testbench
================================

# layer_mem_arb

Arbiter that shares the single layer-memory port (csel/caddr_wr/caddr_rd/cwr/crd/cdata_wr/cdata_rd) between the conv engine, the max-pool engine and a host readback path. Each requester issues one access per grant. An optional lock holds the port across a burst, such as the 4-read pooling window. It sits between the compute engines and the testbench/SRAM memory models, and owns all timing of the memory pins.

## Interface
Parameters:
- NREQ, 3, number of requesters (index 0 = conv, 1 = pool, 2 = host)
- AW, 12, memory address width
- DW, 20, memory data width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester access request, held until granted
- lock  in  NREQ  keep the grant after this beat
- we  in  NREQ  1 = write, 0 = read
- sel  in  3*NREQ  csel code per requester
- addr  in  AW*NREQ  address per requester
- wdata  in  DW*NREQ  write data per requester
- gnt  out  NREQ  one-hot; the beat is accepted this cycle
- rvalid  out  NREQ  one-hot; read data for that requester is on rdata
- rdata  out  DW  read return data, equal to cdata_rd
- csel  out  3  memory select, registered
- cwr  out  1  write strobe, registered
- caddr_wr  out  AW  write address, registered
- cdata_wr  out  DW  write data, registered
- crd  out  1  read strobe, registered
- caddr_rd  out  AW  read address, registered
- cdata_rd  in  DW  memory read data, valid the cycle after crd

## Operation
- FSM states:
  - ARB: round-robin among asserted req. Search starts at last+1 mod NREQ.
  - HOLD: only the owner can be granted; other requesters see gnt=0.
- ARB to HOLD: the granted beat has lock=1.
- HOLD to ARB, either condition:
  - the owner's granted beat has lock=0 (last beat); that beat is still granted;
  - the owner drops req; no grant is given that cycle.
- Pointer update: last := granted index on every grant, in both ARB and HOLD.
- One beat per cycle at most; back-to-back grants to the same or to different requesters are allowed.
- Write beat: in the cycle after gnt, cwr=1, caddr_wr=addr, cdata_wr=wdata, csel=sel, crd=0.
- Read beat: in the cycle after gnt, crd=1, caddr_rd=addr, csel=sel, cwr=0.
- Idle cycles (no grant): cwr=0 and crd=0. csel, caddr_wr, caddr_rd and cdata_wr keep their last values.
- Read return: a 2-deep shift register of {valid, owner index} tracks each read. rvalid[owner] is asserted two cycles after gnt. rdata = cdata_rd combinationally.
- gnt is combinational from req/lock/state/pointer. A requester must keep addr/we/sel/wdata stable while req=1 and gnt=0.
- Reset values:
  - state = ARB; last = NREQ-1, so requester 0 has top priority first;
  - gnt = 0, rvalid = 0;
  - cwr = 0, crd = 0, csel = 0, caddr_wr = 0, caddr_rd = 0, cdata_wr = 0;
  - return pipeline cleared.

## Timing
- Cycle T: gnt[i]=1.
- Cycle T+1: memory strobe on the pins.
- Cycle T+2: rvalid[i]=1 for reads.
- Write latency: 1 cycle. Read latency: 2 cycles after grant.
- Throughput: 1 beat per cycle. A read followed by a write on consecutive cycles is legal, because the read and write address pins are separate.
- Simultaneous req on all inputs with no lock: grants rotate 0, 1, 2, 0, ... with one grant per cycle.
- Reset mid-HOLD or with reads in flight:
  - the lock and the in-flight reads are dropped;
  - no rvalid is produced after reset deasserts;
  - requesters must re-issue.
- req with lock=1 while in HOLD from a non-owner: ignored until release.

## Structure
- Package layer_mem_pkg:
  - AW, DW;
  - csel codes CSEL_NONE=3'b000, CSEL_L0=3'b001, CSEL_L1=3'b011;
  - state enum {ARB, HOLD}.
- Sub-module rr_pick: a combinational NREQ-wide round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: one-hot grant, grant index.
- Everything else (FSM, pin registers, return pipeline) stays in layer_mem_arb.

## Test plan
- Single write: req[0]=1, we=1, sel=1, addr=12'h005, wdata=20'h1234A.
  - gnt[0]=1 at T;
  - at T+1: cwr=1, caddr_wr=5, cdata_wr=1234A, csel=001;
  - at T+2: cwr=0.
- Read return: req[2] read, addr=100; memory model drives cdata_rd=20'h00ABC at T+2.
  - crd=1 and caddr_rd=100 at T+1;
  - rvalid=3'b100 and rdata=00ABC at T+2.
- Rotation: req=3'b111 held for 6 cycles after reset, no lock.
  - grant order 0, 1, 2, 0, 1, 2.
- Locked pool burst: req[1] issues 4 reads at 0, 1, 64, 65 with lock=1, 1, 1, 0, while req[0] is held high.
  - 4 consecutive gnt[1];
  - gnt[0] on the 5th cycle;
  - rvalid[1] is asserted 4 times.
- Lock abandon: the owner drops req in HOLD.
  - state returns to ARB and no grant is given that cycle;
  - next cycle, the pending req[2] is granted.
- Reset mid-burst: assert reset with 2 reads in flight.
  - all outputs are 0 immediately;
  - no rvalid after release;
  - first grant after release goes to requester 0.

Source files
------------

// File: rtl/layer_mem_pkg.sv
// rtl/layer_mem_pkg.sv - shared widths, csel codes and arbiter state for the layer-memory port
package layer_mem_pkg;

  localparam int AW = 12;
  localparam int DW = 20;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts just after the last winner
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/layer_mem_arb.sv
// rtl/layer_mem_arb.sv - shares the single layer-memory port between conv, pool and host readback
module layer_mem_arb
  import layer_mem_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = layer_mem_pkg::AW,
  parameter int DW   = layer_mem_pkg::DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ-1:0]   we,
  input  logic [3*NREQ-1:0] sel,
  input  logic [AW*NREQ-1:0] addr,
  input  logic [DW*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic [2:0]        csel,
  output logic              cwr,
  output logic [AW-1:0]     caddr_wr,
  output logic [DW-1:0]     cdata_wr,
  output logic              crd,
  output logic [AW-1:0]     caddr_rd,
  input  logic [DW-1:0]     cdata_rd
);

  localparam int IW = idx_w(NREQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;

  logic [2:0]      csel_q, csel_d;
  logic            cwr_q, cwr_d;
  logic            crd_q, crd_d;
  logic [AW-1:0]   caddr_wr_q, caddr_wr_d;
  logic [AW-1:0]   caddr_rd_q, caddr_rd_d;
  logic [DW-1:0]   cdata_wr_q, cdata_wr_d;

  logic            ret0_vld_q, ret0_vld_d;
  logic [IW-1:0]   ret0_idx_q, ret0_idx_d;
  logic            ret1_vld_q, ret1_vld_d;
  logic [IW-1:0]   ret1_idx_q, ret1_idx_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [NREQ-1:0] gnt_c;
  logic [IW-1:0]   gidx;
  logic            beat;

  rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req (req),
    .last(last_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_c   = '0;
    gidx    = last_q;
    beat    = 1'b0;
    unique case (state_q)
      ARB: begin
        if (pick_any) begin
          gnt_c = pick_gnt;
          gidx  = pick_idx;
          beat  = 1'b1;
          if (lock[pick_idx]) state_d = HOLD;
        end
      end
      HOLD: begin
        // An owner that lets go of req forfeits the cycle; arbitration resumes next cycle.
        if (req[last_q]) begin
          gnt_c[last_q] = 1'b1;
          beat          = 1'b1;
          if (!lock[last_q]) state_d = ARB;
        end else begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (beat) last_d = gidx;
  end

  always_comb begin
    csel_d     = csel_q;
    caddr_wr_d = caddr_wr_q;
    caddr_rd_d = caddr_rd_q;
    cdata_wr_d = cdata_wr_q;
    cwr_d      = 1'b0;
    crd_d      = 1'b0;
    ret0_vld_d = 1'b0;
    ret0_idx_d = gidx;
    ret1_vld_d = ret0_vld_q;
    ret1_idx_d = ret0_idx_q;
    if (beat) begin
      csel_d = sel[int'(gidx)*3 +: 3];
      if (we[gidx]) begin
        cwr_d      = 1'b1;
        caddr_wr_d = addr[int'(gidx)*AW +: AW];
        cdata_wr_d = wdata[int'(gidx)*DW +: DW];
      end else begin
        crd_d      = 1'b1;
        caddr_rd_d = addr[int'(gidx)*AW +: AW];
        ret0_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      last_q     <= LAST_RST;
      csel_q     <= CSEL_NONE;
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
      ret0_vld_q <= 1'b0;
      ret0_idx_q <= '0;
      ret1_vld_q <= 1'b0;
      ret1_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      csel_q     <= csel_d;
      cwr_q      <= cwr_d;
      crd_q      <= crd_d;
      caddr_wr_q <= caddr_wr_d;
      caddr_rd_q <= caddr_rd_d;
      cdata_wr_q <= cdata_wr_d;
      ret0_vld_q <= ret0_vld_d;
      ret0_idx_q <= ret0_idx_d;
      ret1_vld_q <= ret1_vld_d;
      ret1_idx_q <= ret1_idx_d;
    end
  end

  always_comb begin
    rvalid = '0;
    if (ret1_vld_q) rvalid[ret1_idx_q] = 1'b1;
  end

  // Grants are combinational, so mask them while reset is held.
  assign gnt      = reset ? '0 : gnt_c;
  assign rdata    = cdata_rd;
  assign csel     = csel_q;
  assign cwr      = cwr_q;
  assign crd      = crd_q;
  assign caddr_wr = caddr_wr_q;
  assign caddr_rd = caddr_rd_q;
  assign cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_layer_mem_arb.sv
// tb/tb_layer_mem_arb.sv - directed self-checking bench for layer_mem_arb
module tb_layer_mem_arb;

  localparam int NREQ = 3;
  localparam int AW   = 12;
  localparam int DW   = 20;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req, lock, we;
  logic [3*NREQ-1:0] sel;
  logic [AW*NREQ-1:0] addr;
  logic [DW*NREQ-1:0] wdata;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic [2:0]        csel;
  logic              cwr, crd;
  logic [AW-1:0]     caddr_wr, caddr_rd;
  logic [DW-1:0]     cdata_wr, cdata_rd;

  int checks = 0;
  int failures = 0;

  layer_mem_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .sel(sel),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    case (a)
      12'd100: rd_val = 20'h00ABC;
      12'd0:   rd_val = 20'h11111;
      12'd1:   rd_val = 20'h22222;
      12'd64:  rd_val = 20'h33333;
      12'd65:  rd_val = 20'h44444;
      default: rd_val = {8'h00, a};
    endcase
  endfunction

  // Memory model: read data appears the cycle after crd.
  initial cdata_rd = '0;
  always @(posedge clk) if (crd) cdata_rd <= rd_val(caddr_rd);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input logic r, input logic l, input logic w,
                          input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r; lock[i] = l; we[i] = w;
    sel[i*3 +: 3] = s; addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    req = '0; lock = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 3'b111; lock = '0; we = '0; sel = '0; addr = '0; wdata = '0;
    cyc(); cyc();
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL rst_gnt: got %b want 000", gnt); end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rst_rvalid: got %b want 000", rvalid); end
    checks++; if (cwr !== 1'b0) begin failures++; $display("FAIL rst_cwr: got %b want 0", cwr); end
    checks++; if (crd !== 1'b0) begin failures++; $display("FAIL rst_crd: got %b want 0", crd); end
    checks++; if (csel !== 3'b000) begin failures++; $display("FAIL rst_csel: got %b want 000", csel); end
    checks++; if (caddr_wr !== 12'h000) begin failures++; $display("FAIL rst_caddr_wr: got %h want 000", caddr_wr); end
    checks++; if (caddr_rd !== 12'h000) begin failures++; $display("FAIL rst_caddr_rd: got %h want 000", caddr_rd); end
    checks++; if (cdata_wr !== 20'h0) begin failures++; $display("FAIL rst_cdata_wr: got %h want 00000", cdata_wr); end
    clear_reqs();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single_write();
    set_beat(0, 1'b1, 1'b0, 1'b1, 3'b001, 12'h005, 20'h1234A);
    #1;
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL wr_gnt: got %b want 001", gnt); end
    cyc();
    clear_reqs();
    #1;
    checks++; if (cwr !== 1'b1) begin failures++; $display("FAIL wr_cwr: got %b want 1", cwr); end
    checks++; if (caddr_wr !== 12'h005) begin failures++; $display("FAIL wr_caddr: got %h want 005", caddr_wr); end
    checks++; if (cdata_wr !== 20'h1234A) begin failures++; $display("FAIL wr_cdata: got %h want 1234a", cdata_wr); end
    checks++; if (csel !== 3'b001) begin failures++; $display("FAIL wr_csel: got %b want 001", csel); end
    checks++; if (crd !== 1'b0) begin failures++; $display("FAIL wr_crd: got %b want 0", crd); end
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL wr_idle_gnt: got %b want 000", gnt); end
    cyc();
    checks++; if (cwr !== 1'b0) begin failures++; $display("FAIL wr_cwr_off: got %b want 0", cwr); end
    checks++; if (csel !== 3'b001) begin failures++; $display("FAIL wr_csel_hold: got %b want 001", csel); end
  endtask

  task automatic test_read_return();
    set_beat(2, 1'b1, 1'b0, 1'b0, 3'b011, 12'd100, 20'h0);
    #1;
    checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL rd_gnt: got %b want 100", gnt); end
    cyc();
    clear_reqs();
    #1;
    checks++; if (crd !== 1'b1) begin failures++; $display("FAIL rd_crd: got %b want 1", crd); end
    checks++; if (caddr_rd !== 12'd100) begin failures++; $display("FAIL rd_caddr: got %0d want 100", caddr_rd); end
    checks++; if (cwr !== 1'b0) begin failures++; $display("FAIL rd_cwr: got %b want 0", cwr); end
    checks++; if (csel !== 3'b011) begin failures++; $display("FAIL rd_csel: got %b want 011", csel); end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rd_early_rvalid: got %b want 000", rvalid); end
    cyc();
    checks++; if (rvalid !== 3'b100) begin failures++; $display("FAIL rd_rvalid: got %b want 100", rvalid); end
    checks++; if (rdata !== 20'h00ABC) begin failures++; $display("FAIL rd_rdata: got %h want 00abc", rdata); end
    cyc();
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rd_rvalid_off: got %b want 000", rvalid); end
    checks++; if (crd !== 1'b0) begin failures++; $display("FAIL rd_crd_off: got %b want 0", crd); end
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] exp;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_beat(i, 1'b1, 1'b0, 1'b1, 3'b001, AW'(200 + i), DW'(i));
    for (int k = 0; k < 6; k++) begin
      #1;
      exp = 3'b001 << (k % 3);
      checks++; if (gnt !== exp) begin failures++; $display("FAIL rot_gnt[%0d]: got %b want %b", k, gnt, exp); end
      cyc();
    end
    clear_reqs();
    cyc(); cyc();
  endtask

  task automatic test_lock_burst();
    logic [AW-1:0]   addrs [4];
    logic [DW-1:0]   datas [4];
    logic [NREQ-1:0] exp_g, exp_v;
    int nval;
    addrs[0] = 12'd0;     addrs[1] = 12'd1;     addrs[2] = 12'd64;    addrs[3] = 12'd65;
    datas[0] = 20'h11111; datas[1] = 20'h22222; datas[2] = 20'h33333; datas[3] = 20'h44444;
    nval = 0;
    set_beat(0, 1'b1, 1'b0, 1'b1, 3'b001, 12'd300, 20'h5);
    #1;
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL burst_prime: got %b want 001", gnt); end
    cyc();
    set_beat(0, 1'b1, 1'b0, 1'b1, 3'b001, 12'd301, 20'h6);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) set_beat(1, 1'b1, (c < 3), 1'b0, 3'b011, addrs[c], 20'h0);
      else       set_beat(1, 1'b0, 1'b0, 1'b0, 3'b011, 12'd0, 20'h0);
      if (c >= 5) set_beat(0, 1'b0, 1'b0, 1'b1, 3'b001, 12'd301, 20'h6);
      #1;
      exp_g = (c < 4) ? 3'b010 : ((c == 4) ? 3'b001 : 3'b000);
      exp_v = (c >= 2 && c <= 5) ? 3'b010 : 3'b000;
      checks++; if (gnt !== exp_g) begin failures++; $display("FAIL burst_gnt[%0d]: got %b want %b", c, gnt, exp_g); end
      checks++; if (rvalid !== exp_v) begin failures++; $display("FAIL burst_rvalid[%0d]: got %b want %b", c, rvalid, exp_v); end
      if (rvalid[1]) nval++;
      if (c >= 2 && c <= 5) begin
        checks++;
        if (rdata !== datas[c-2]) begin failures++; $display("FAIL burst_rdata[%0d]: got %h want %h", c, rdata, datas[c-2]); end
      end
      cyc();
    end
    checks++; if (nval != 4) begin failures++; $display("FAIL burst_rvalid_count: got %0d want 4", nval); end
  endtask

  task automatic test_lock_abandon();
    set_beat(1, 1'b1, 1'b1, 1'b0, 3'b011, 12'd10, 20'h0);
    set_beat(2, 1'b1, 1'b0, 1'b1, 3'b001, 12'd20, 20'h00055);
    #1;
    checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL abn_lock_gnt: got %b want 010", gnt); end
    cyc();
    set_beat(1, 1'b0, 1'b0, 1'b0, 3'b011, 12'd10, 20'h0);
    #1;
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL abn_drop_gnt: got %b want 000", gnt); end
    cyc();
    checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL abn_next_gnt: got %b want 100", gnt); end
    checks++; if (cwr !== 1'b0 || crd !== 1'b0) begin failures++; $display("FAIL abn_idle_pins: got cwr=%b crd=%b want 0 0", cwr, crd); end
    checks++; if (rvalid !== 3'b010) begin failures++; $display("FAIL abn_rvalid: got %b want 010", rvalid); end
    cyc();
    clear_reqs();
    #1;
    checks++; if (cwr !== 1'b1 || caddr_wr !== 12'd20 || cdata_wr !== 20'h00055) begin
      failures++; $display("FAIL abn_write: got cwr=%b addr=%0d data=%h want 1 20 00055", cwr, caddr_wr, cdata_wr);
    end
    cyc(); cyc();
  endtask

  task automatic test_reset_midburst();
    set_beat(0, 1'b1, 1'b1, 1'b0, 3'b001, 12'd400, 20'h0);
    #1;
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL mid_gnt0: got %b want 001", gnt); end
    cyc();
    set_beat(0, 1'b1, 1'b1, 1'b0, 3'b001, 12'd401, 20'h0);
    set_beat(2, 1'b1, 1'b0, 1'b1, 3'b011, 12'd402, 20'h7);
    #1;
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL mid_gnt1: got %b want 001", gnt); end
    cyc();
    reset = 1'b1;
    #1;
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL mid_rst_gnt: got %b want 000", gnt); end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL mid_rst_rvalid: got %b want 000", rvalid); end
    checks++; if (cwr !== 1'b0 || crd !== 1'b0) begin failures++; $display("FAIL mid_rst_strobes: got cwr=%b crd=%b want 0 0", cwr, crd); end
    checks++; if (csel !== 3'b000 || caddr_rd !== 12'd0 || caddr_wr !== 12'd0 || cdata_wr !== 20'd0) begin
      failures++; $display("FAIL mid_rst_pins: got csel=%b ard=%h awr=%h dwr=%h want all 0", csel, caddr_rd, caddr_wr, cdata_wr);
    end
    clear_reqs();
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL mid_post_rvalid[%0d]: got %b want 000", c, rvalid); end
      cyc();
    end
    set_beat(0, 1'b1, 1'b0, 1'b1, 3'b001, 12'd410, 20'h1);
    set_beat(2, 1'b1, 1'b0, 1'b1, 3'b001, 12'd412, 20'h2);
    #1;
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL mid_first_gnt: got %b want 001", gnt); end
    cyc();
    clear_reqs();
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_return();
    test_rotation();
    test_lock_burst();
    test_lock_abandon();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
